udp_axis_slave: RTL and testbench

- Streaming UDP source for the Ethernet stack; the transmit counterpart of the UDP-to-AXIS DAC path.
- Accepts an 8-bit AXI-Stream byte stream (e.g. ADC samples) into an internal FIFO and packetizes it into UDP datagrams on one switch port of udp_switch.
- A remote host subscribes by sending any datagram to UDP_PORT. Data is then sent to that host's IP and source port.

---
 rtl/udp_axis_slave.sv | 196 +++++++++++++++++++
 tb/tb_udp_axis_slave.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_axis_slave.sv
// Streaming UDP source: buffers an 8-bit AXI-Stream in a byte FIFO and emits it as UDP
// datagrams to the last host that sent us a datagram (subscription by any RX header).
module udp_axis_slave #(
    parameter logic [15:0] UDP_PORT       = 16'd1233,
    parameter int          PAYLOAD_BYTES  = 1024,
    parameter int          FIFO_DEPTH     = 2048,
    parameter int          TIMEOUT_CYCLES = 125000,
    parameter logic [7:0]  IP_TTL         = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] local_ip,
    // Every *_valid/*_ready pair: transfer occurs on a rising clk edge where both are 1;
    // a source holds valid and its data stable until that transfer.
    input  logic [7:0]  in_axis_tdata,
    input  logic        in_axis_tvalid,
    output logic        in_axis_tready,
    output logic        udp_tx_hdr_valid,
    input  logic        udp_tx_hdr_ready,
    output logic [5:0]  udp_tx_ip_dscp,
    output logic [1:0]  udp_tx_ip_ecn,
    output logic [7:0]  udp_tx_ip_ttl,
    output logic [31:0] udp_tx_ip_source_ip,
    output logic [31:0] udp_tx_ip_dest_ip,
    output logic [15:0] udp_tx_source_port,
    output logic [15:0] udp_tx_dest_port,
    output logic [15:0] udp_tx_length,
    output logic [15:0] udp_tx_checksum,
    output logic [7:0]  udp_tx_payload_tdata,
    output logic        udp_tx_payload_tvalid,
    input  logic        udp_tx_payload_tready,
    output logic        udp_tx_payload_tlast,
    output logic        udp_tx_payload_tuser,
    input  logic        udp_rx_hdr_valid,
    output logic        udp_rx_hdr_ready,
    input  logic [31:0] udp_rx_ip_source_ip,
    input  logic [15:0] udp_rx_source_port,
    output logic        udp_rx_payload_tready,
    output logic        subscribed,
    output logic        overflow,
    output logic [31:0] packets_sent,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_HEADER  = 2'd2;
    localparam logic [1:0] S_PAYLOAD = 2'd3;

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] P_CNT    = PAYLOAD_BYTES[AW:0];
    localparam logic [15:0] P_LEN    = PAYLOAD_BYTES[15:0];
    localparam logic [31:0] TMO      = TIMEOUT_CYCLES[31:0];

    logic [1:0]    state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]   timer_q, timer_d;
    logic [15:0]   n_q, n_d, remaining_q, remaining_d;
    logic [31:0]   hdr_ip_q, hdr_ip_d, dest_ip_q, dest_ip_d;
    logic [15:0]   hdr_port_q, hdr_port_d, dest_port_q, dest_port_d;
    logic          subscribed_q, subscribed_d, overflow_q, overflow_d;
    logic [31:0]   packets_q, packets_d;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic        full, push, pop, last_beat, start;
    logic [15:0] start_n;

    assign full      = (count_q == FULL_CNT);
    // Before a subscription exists the producer is never stalled; its bytes are dropped.
    assign push      = subscribed_q && in_axis_tvalid && !full;
    assign pop       = (state_q == S_PAYLOAD) && udp_tx_payload_tready;
    assign last_beat = pop && (remaining_q == 16'd1);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= in_axis_tdata;
    end

    always_comb begin
        count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        overflow_d   = overflow_q | (subscribed_q && in_axis_tvalid && full);
        subscribed_d = subscribed_q | udp_rx_hdr_valid;
        dest_ip_d    = udp_rx_hdr_valid ? udp_rx_ip_source_ip : dest_ip_q;
        dest_port_d  = udp_rx_hdr_valid ? udp_rx_source_port : dest_port_q;
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        n_d         = n_q;
        remaining_d = remaining_q;
        hdr_ip_d    = hdr_ip_q;
        hdr_port_d  = hdr_port_q;
        packets_d   = packets_q;
        start       = 1'b0;
        start_n     = 16'd0;
        case (state_q)
            S_IDLE: if (subscribed_q) state_d = S_WAIT;
            S_WAIT: begin
                if (push) timer_d = '0;
                else if (count_q != '0 && timer_q != TMO) timer_d = timer_q + 32'd1;
                if (count_q >= P_CNT) begin
                    start   = 1'b1;
                    start_n = P_LEN;
                end else if (TMO != 32'd0 && timer_q == TMO && count_q != '0) begin
                    start   = 1'b1;
                    start_n = 16'(count_q);
                end
            end
            S_HEADER: if (udp_tx_hdr_ready) state_d = S_PAYLOAD;
            S_PAYLOAD: begin
                if (pop) remaining_d = remaining_q - 16'd1;
                if (last_beat) begin
                    packets_d = packets_q + 32'd1;
                    state_d   = S_WAIT;
                    timer_d   = '0;
                    // Skip the WAIT cycle when a full datagram is already buffered.
                    if (count_d >= P_CNT) begin
                        start   = 1'b1;
                        start_n = P_LEN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The destination is frozen here so a re-subscription never splits a datagram.
        if (start) begin
            state_d     = S_HEADER;
            n_d         = start_n;
            remaining_d = start_n;
            hdr_ip_d    = dest_ip_q;
            hdr_port_d  = dest_port_q;
            timer_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            timer_q      <= '0;
            n_q          <= '0;
            remaining_q  <= '0;
            hdr_ip_q     <= '0;
            hdr_port_q   <= '0;
            dest_ip_q    <= '0;
            dest_port_q  <= '0;
            subscribed_q <= 1'b0;
            overflow_q   <= 1'b0;
            packets_q    <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            timer_q      <= timer_d;
            n_q          <= n_d;
            remaining_q  <= remaining_d;
            hdr_ip_q     <= hdr_ip_d;
            hdr_port_q   <= hdr_port_d;
            dest_ip_q    <= dest_ip_d;
            dest_port_q  <= dest_port_d;
            subscribed_q <= subscribed_d;
            overflow_q   <= overflow_d;
            packets_q    <= packets_d;
        end
    end

    assign in_axis_tready        = subscribed_q ? !full : 1'b1;
    assign udp_tx_hdr_valid      = (state_q == S_HEADER);
    assign udp_tx_ip_dscp        = 6'd0;
    assign udp_tx_ip_ecn         = 2'd0;
    assign udp_tx_ip_ttl         = IP_TTL;
    assign udp_tx_ip_source_ip   = local_ip;
    assign udp_tx_ip_dest_ip     = hdr_ip_q;
    assign udp_tx_source_port    = UDP_PORT;
    assign udp_tx_dest_port      = hdr_port_q;
    assign udp_tx_length         = n_q + 16'd8;
    assign udp_tx_checksum       = 16'd0;
    assign udp_tx_payload_tdata  = fifo_mem[rd_ptr_q];
    assign udp_tx_payload_tvalid = (state_q == S_PAYLOAD);
    assign udp_tx_payload_tlast  = (state_q == S_PAYLOAD) && (remaining_q == 16'd1);
    assign udp_tx_payload_tuser  = 1'b0;
    assign udp_rx_hdr_ready      = 1'b1;
    assign udp_rx_payload_tready = 1'b1;
    assign subscribed            = subscribed_q;
    assign overflow              = overflow_q;
    assign packets_sent          = packets_q;
    assign fsm_state             = state_q;

endmodule

// File: tb/tb_udp_axis_slave.sv
// Bench for udp_axis_slave: random byte streams scored against a byte-queue model of the
// datagram stream (subscription, full/partial datagrams, backpressure, reset abort).
module tb_udp_axis_slave;
    localparam int PB  = 1024;
    localparam int FD  = 2048;
    localparam int TMO = 50;
    localparam logic [31:0] LOCAL_IP = 32'hC0A8_0105;

    logic        clk, reset;
    logic [7:0]  in_tdata;
    logic        in_tvalid, in_tready;
    logic        hdr_valid, hdr_ready;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [7:0]  ttl;
    logic [31:0] sip, dip;
    logic [15:0] sport, dport, len, csum;
    logic [7:0]  tdata;
    logic        tvalid, tready, tlast, tuser;
    logic        rx_valid, rx_ready;
    logic [31:0] rx_ip;
    logic [15:0] rx_port;
    logic        rx_pay_ready, subscribed, overflow;
    logic [31:0] packets_sent;
    logic [1:0]  fsm_state;

    udp_axis_slave #(.UDP_PORT(16'd1233), .PAYLOAD_BYTES(PB), .FIFO_DEPTH(FD),
                     .TIMEOUT_CYCLES(TMO), .IP_TTL(8'd64)) dut (
        .clk(clk), .reset(reset), .local_ip(LOCAL_IP),
        .in_axis_tdata(in_tdata), .in_axis_tvalid(in_tvalid), .in_axis_tready(in_tready),
        .udp_tx_hdr_valid(hdr_valid), .udp_tx_hdr_ready(hdr_ready),
        .udp_tx_ip_dscp(dscp), .udp_tx_ip_ecn(ecn), .udp_tx_ip_ttl(ttl),
        .udp_tx_ip_source_ip(sip), .udp_tx_ip_dest_ip(dip),
        .udp_tx_source_port(sport), .udp_tx_dest_port(dport),
        .udp_tx_length(len), .udp_tx_checksum(csum),
        .udp_tx_payload_tdata(tdata), .udp_tx_payload_tvalid(tvalid),
        .udp_tx_payload_tready(tready), .udp_tx_payload_tlast(tlast),
        .udp_tx_payload_tuser(tuser),
        .udp_rx_hdr_valid(rx_valid), .udp_rx_hdr_ready(rx_ready),
        .udp_rx_ip_source_ip(rx_ip), .udp_rx_source_port(rx_port),
        .udp_rx_payload_tready(rx_pay_ready),
        .subscribed(subscribed), .overflow(overflow), .packets_sent(packets_sent),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // scoreboard state
    logic [7:0]  exp_q[$];
    logic [31:0] got_dest_q[$];
    logic [15:0] got_dport_q[$];
    logic [15:0] got_len_q[$];
    logic        model_sub = 1'b0;
    logic [31:0] model_dip = '0;
    logic [15:0] model_dport = '0;
    bit          in_hdr = 0, in_pay = 0;
    int          exp_n = 0, beat = 0, model_sent = 0, hdr_count = 0, stall_cycles = 0;
    logic [31:0] exp_dip;
    logic [15:0] exp_dport;
    int          tr_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // downstream ready generators
    initial begin
        tready = 1'b0;
        hdr_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tready    = (tr_mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
            hdr_ready = $urandom_range(0, 1) != 0;
        end
    end

    // monitor + reference model
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_sub = 1'b0; model_dip = '0; model_dport = '0;
            in_hdr = 0; in_pay = 0; model_sent = 0;
        end else begin
            if (hdr_valid && !in_hdr) begin
                in_hdr    = 1;
                exp_n     = (exp_q.size() >= PB) ? PB : exp_q.size();
                exp_dip   = model_dip;
                exp_dport = model_dport;
            end
            if (hdr_valid && hdr_ready) begin
                check("hdr_len", 32'(len), 32'(exp_n + 8));
                check("hdr_dip", dip, exp_dip);
                check("hdr_dport", 32'(dport), 32'(exp_dport));
                check("hdr_sip", sip, LOCAL_IP);
                check("hdr_sport", 32'(sport), 32'd1233);
                check("hdr_ttl", 32'(ttl), 32'd64);
                check("hdr_dscp_ecn_csum", {16'(dscp), csum} | 32'(ecn), 32'd0);
                got_dest_q.push_back(dip);
                got_dport_q.push_back(dport);
                got_len_q.push_back(len);
                hdr_count++;
                in_hdr = 0; in_pay = 1; beat = 0;
            end
            if (tvalid && tready) begin
                check("pay_in_pkt", 32'(in_pay), 32'd1);
                if (exp_q.size() == 0) check("pay_underrun", 32'd1, 32'd0);
                else check("pay_data", 32'(tdata), 32'(exp_q.pop_front()));
                check("pay_tlast", 32'(tlast), 32'(beat == exp_n - 1));
                check("pay_tuser", 32'(tuser), 32'd0);
                beat++;
                if (beat >= exp_n) begin
                    in_pay = 0;
                    model_sent++;
                end
            end
            if (in_tvalid && in_tready && model_sub) exp_q.push_back(in_tdata);
            if (rx_valid) begin
                model_sub = 1'b1; model_dip = rx_ip; model_dport = rx_port;
            end
        end
    end

    // driver tasks
    task automatic send_bytes(input int n, input bit ramp, input int gap_max);
        int cyc;
        for (int i = 0; i < n; i++) begin
            in_tdata  = ramp ? 8'(i) : 8'($urandom);
            in_tvalid = 1'b1;
            @(negedge clk);
            cyc = 0;
            while (!in_tready && cyc < 5000) begin
                stall_cycles++;
                @(negedge clk);
                cyc++;
            end
            if (!in_tready) begin
                check("in_stall_timeout", 32'd0, 32'd1);
                in_tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_tvalid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic rx_header(input logic [31:0] ip, input logic [15:0] port);
        rx_valid = 1'b1; rx_ip = ip; rx_port = port;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_sent(input int target);
        int n = 0;
        while (model_sent < target && n < 30000) begin @(negedge clk); n++; end
        check("wait_sent", 32'(model_sent >= target), 32'd1);
        @(posedge clk); #1;
        check("packets_sent", packets_sent, 32'(target));
    endtask

    task automatic wait_tvalid();
        int n = 0;
        while (!tvalid && n < 20000) begin @(negedge clk); n++; end
        check("wait_tvalid", 32'(tvalid), 32'd1);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; in_tvalid = 1'b0; in_tdata = '0;
        rx_valid = 1'b0; rx_ip = '0; rx_port = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_subscribed", 32'(subscribed), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_packets", packets_sent, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // no subscription: producer never stalls, nothing sent
        stall_cycles = 0;
        send_bytes(3000, 1'b0, 0);
        repeat (100) @(posedge clk); #1;
        check("nosub_stall", 32'(stall_cycles), 32'd0);
        check("nosub_hdrs", 32'(hdr_count), 32'd0);
        check("nosub_packets", packets_sent, 32'd0);
        check("nosub_subscribed", 32'(subscribed), 32'd0);
        check("nosub_rx_ready", 32'(rx_ready & rx_pay_ready), 32'd1);

        // two full datagrams of a ramp
        rx_header(32'h0A00_0002, 16'd5000);
        check("sub_set", 32'(subscribed), 32'd1);
        send_bytes(2048, 1'b1, 2);
        wait_sent(2);
        check("full_len0", 32'(got_len_q[0]), 32'd1032);
        check("full_len1", 32'(got_len_q[1]), 32'd1032);
        check("full_dest0", got_dest_q[0], 32'h0A00_0002);
        check("full_dport1", 32'(got_dport_q[1]), 32'd5000);
        check("full_ovf", 32'(overflow), 32'd0);

        // partial datagram flushed after the idle timeout
        send_bytes(100, 1'b0, 0);
        cyc = 0;
        while (!hdr_valid && cyc < 200) begin @(negedge clk); cyc++; end
        check("tmo_not_early", 32'(cyc >= 48), 32'd1);
        check("tmo_not_late", 32'(cyc <= 56), 32'd1);
        wait_sent(3);
        check("tmo_len", 32'(got_len_q[2]), 32'd108);

        // re-subscription during a payload applies to the next datagram
        fork
            send_bytes(2048, 1'b0, 2);
            begin
                wait_tvalid();
                @(posedge clk); #1;
                rx_header(32'h0A00_0003, 16'd6000);
            end
        join
        wait_sent(5);
        check("resub_old_ip", got_dest_q[3], 32'h0A00_0002);
        check("resub_new_ip", got_dest_q[4], 32'h0A00_0003);
        check("resub_new_port", 32'(got_dport_q[4]), 32'd6000);

        // downstream stalled: FIFO fills, producer is back-pressured, nothing lost
        check("bp_ovf_before", 32'(overflow), 32'd0);
        tr_mode = 1;
        fork
            send_bytes(2060, 1'b0, 1);
            begin
                cyc = 0;
                while (in_tready && cyc < 10000) begin @(negedge clk); cyc++; end
                check("bp_full_seen", 32'(in_tready), 32'd0);
                @(negedge clk); @(negedge clk);
                check("bp_overflow", 32'(overflow), 32'd1);
                check("bp_fifo_level", 32'(exp_q.size()), 32'(FD));
                @(posedge clk); #1;
                tr_mode = 0;
            end
        join
        wait_sent(8);
        check("bp_tail_len", 32'(got_len_q[7]), 32'd20);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a payload aborts it
        tr_mode = 1;
        send_bytes(1100, 1'b0, 0);
        wait_tvalid();
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_hdr_valid", 32'(hdr_valid), 32'd0);
        check("abort_tvalid", 32'(tvalid), 32'd0);
        check("abort_tlast", 32'(tlast), 32'd0);
        check("abort_subscribed", 32'(subscribed), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_packets", packets_sent, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tr_mode = 0;
        @(posedge clk); #1;
        rx_header(32'h0A00_0009, 16'd7000);
        send_bytes(1024, 1'b1, 1);
        wait_sent(1);
        check("after_rst_dest", got_dest_q[got_dest_q.size() - 1], 32'h0A00_0009);
        check("after_rst_len", 32'(got_len_q[got_len_q.size() - 1]), 32'd1032);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
